// File: rtl/program_sequencer.sv
// Instruction sequencer: walks pc through a program with one-cycle fetch and
// execute phases, stretches loads over LOAD_LAT cycles, and supports table-driven branches.
module program_sequencer #(
  parameter int          PCW       = 10,
  parameter int          LOAD_LAT  = 2,
  parameter logic [8:0]  HALT_WORD = 9'h1FF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [8:0]     instr,
  input  logic           branch,
  input  logic [1:0]     target_sel,
  input  logic           cfg_we,
  input  logic [1:0]     cfg_idx,
  input  logic [PCW-1:0] cfg_data,
  output logic [PCW-1:0] pc,
  output logic           instr_valid,
  output logic           mem_wait,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [2:0]     OP_LOAD = 3'b101;
  localparam logic [2:0]     LAT3    = 3'(LOAD_LAT);
  localparam logic [PCW-1:0] PC_MAX  = {PCW{1'b1}};
  localparam logic [PCW-1:0] PC_ONE  = {{(PCW-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [PCW-1:0] tbl_q [4];
  logic [PCW-1:0] tbl_d [4];
  logic           tbl_we;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) state_d = FETCH;
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (instr == HALT_WORD) begin
          state_d = DONE;
        end else if (instr[8:6] == OP_LOAD) begin
          state_d = MEMWAIT;
          cnt_d   = LAT3;
        end else if (branch) begin
          pc_d    = tbl_q[target_sel];
          state_d = FETCH;
        end else if (pc_q == PC_MAX) begin
          state_d = DONE;
        end else begin
          pc_d    = pc_q + PC_ONE;
          state_d = FETCH;
        end
      end
      MEMWAIT: begin
        // Counter is loaded with LOAD_LAT on entry, so leaving at 1 gives LOAD_LAT cycles.
        if (cnt_q <= 3'd1) begin
          cnt_d = '0;
          if (pc_q == PC_MAX) begin
            state_d = DONE;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Table is only writable while the program is stopped, so a running branch never races a write.
  assign tbl_we = cfg_we && ((state_q == IDLE) || (state_q == DONE));

  for (genvar gi = 0; gi < 4; gi++) begin : g_tbl
    always_comb begin
      tbl_d[gi] = tbl_q[gi];
      if (tbl_we && (cfg_idx == 2'(gi))) tbl_d[gi] = cfg_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tbl_q[gi] <= '0;
      else          tbl_q[gi] <= tbl_d[gi];
    end
  end

  assign pc          = pc_q;
  assign instr_valid = (state_q == EXEC);
  assign mem_wait    = (state_q == MEMWAIT);
  assign busy        = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEMWAIT);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: expected EXEC pcs/spacing and done events are queued per
// program; a negedge monitor pops and compares as the DUT presents them.
module tb_program_sequencer;
  localparam int         PCW  = 10;
  localparam int         LAT  = 2;
  localparam logic [8:0] HALT = 9'h1FF;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [8:0]     instr;
  logic           branch;
  logic [1:0]     target_sel;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_idx = 2'd0;
  logic [PCW-1:0] cfg_data = '0;
  logic [PCW-1:0] pc;
  logic           instr_valid, mem_wait, busy, done;

  logic [8:0] prog_mem [0:1023];
  logic       br_mem   [0:1023];

  always #5 clk = ~clk;

  assign instr      = prog_mem[pc];
  assign branch     = br_mem[pc];
  assign target_sel = instr[4:3];

  program_sequencer #(.PCW(PCW), .LOAD_LAT(LAT), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .branch(branch),
    .target_sel(target_sel), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .pc(pc), .instr_valid(instr_valid), .mem_wait(mem_wait), .busy(busy), .done(done)
  );

  typedef struct { int pc; int gap; int mw; } exec_t;
  typedef struct { int pc; int lag; } done_t;
  exec_t exec_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: gap = cycles since previous EXEC, mw = mem_wait cycles since previous EXEC.
  initial begin
    int    gap = 0;
    int    mw = 0;
    logic  done_prev = 1'b0;
    exec_t e;
    done_t d;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        gap = 0; mw = 0; done_prev = 1'b0;
      end else begin
        gap++;
        if (mem_wait) mw++;
        if (instr_valid) begin
          if (exec_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_exec: got pc=%0d, expected no instr_valid", pc);
          end else begin
            e = exec_q.pop_front();
            chk("exec_pc", int'(pc), e.pc);
            if (e.gap != 0) chk("exec_gap", gap, e.gap);
            chk("exec_memwait_cycles", mw, e.mw);
            $display("exec pc=%0d gap=%0d mw=%0d", pc, gap, mw);
          end
          gap = 0; mw = 0;
        end
        if (done && !done_prev) begin
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 at pc=%0d, expected none", pc);
          end else begin
            d = done_q.pop_front();
            chk("done_pc", int'(pc), d.pc);
            chk("done_lag", gap, d.lag);
            $display("done pc=%0d lag=%0d", pc, gap);
          end
        end
        done_prev = done;
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      prog_mem[i] = 9'h000;
      br_mem[i]   = 1'b0;
    end
  endtask

  task automatic push_exec(input int p, input int g, input int m);
    exec_t e;
    e.pc = p; e.gap = g; e.mw = m;
    exec_q.push_back(e);
  endtask

  task automatic push_done(input int p);
    done_t d;
    d.pc = p; d.lag = 1;
    done_q.push_back(d);
  endtask

  // Ends at a negedge with reset_n just released.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", int'(pc), 0);
    chk("rst_flags", {28'd0, instr_valid, mem_wait, busy, done}, 0);
    reset_n = 1'b1;
  endtask

  // Caller is at a negedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic cfg_write(input int idx, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_data = PCW'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(done && exec_q.size() == 0 && done_q.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: got no completion in %0d cycles, expected done", name, n);
    end
  endtask

  initial begin
    int n;
    clear_prog();

    // Straight line; start issued on the edge right after reset release.
    prog_mem[3] = HALT;
    for (int i = 0; i < 4; i++) push_exec(i, (i == 0) ? 0 : 2, 0);
    push_done(3);
    do_reset();
    pulse_start();
    wait_done("straight");
    repeat (3) @(negedge clk);
    chk("done_hold", int'(done), 1);
    chk("done_hold_pc", int'(pc), 3);

    // Branches, including a table write coincident with start.
    clear_prog();
    prog_mem[1] = 9'h010; br_mem[1] = 1'b1;
    prog_mem[40] = 9'h008; br_mem[40] = 1'b1;
    prog_mem[20] = HALT;
    push_exec(0, 0, 0); push_exec(1, 2, 0); push_exec(40, 2, 0); push_exec(20, 2, 0);
    push_done(20);
    do_reset();
    cfg_write(2, 40);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_data = 10'd20;
    start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_done("branch");

    // Load at pc 5, restarted from DONE.
    clear_prog();
    prog_mem[5] = 9'h140;
    prog_mem[6] = HALT;
    for (int i = 0; i < 6; i++) push_exec(i, (i == 0) ? 0 : 2, 0);
    push_exec(6, 4, 2);
    push_done(6);
    @(negedge clk);
    pulse_start();
    wait_done("load");

    // Config writes and start pulses while busy must be dropped.
    clear_prog();
    br_mem[6] = 1'b1;
    prog_mem[30] = HALT;
    do_reset();
    cfg_write(0, 30);
    for (int i = 0; i < 7; i++) push_exec(i, (i == 0) ? 0 : 2, 0);
    push_exec(30, 2, 0);
    push_done(30);
    pulse_start();
    repeat (2) @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_data = 10'd99; start = 1'b1;
    repeat (4) @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_done("illegal_cfg");

    // pc at all-ones with a plain instruction ends without wrapping.
    clear_prog();
    prog_mem[0] = 9'h018; br_mem[0] = 1'b1;
    do_reset();
    cfg_write(3, 1023);
    push_exec(0, 0, 0); push_exec(1023, 2, 0);
    push_done(1023);
    pulse_start();
    wait_done("wrap");
    repeat (2) @(negedge clk);
    chk("wrap_pc_hold", int'(pc), 1023);

    // Reset during MEMWAIT clears outputs at once and no EXEC follows.
    clear_prog();
    prog_mem[0] = 9'h140;
    do_reset();
    push_exec(0, 0, 0);
    pulse_start();
    n = 0;
    while (!mem_wait && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_memwait", int'(mem_wait), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pc", int'(pc), 0);
    chk("async_rst_flags", {28'd0, instr_valid, mem_wait, busy, done}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle_busy", int'(busy), 0);
    chk("exec_queue_drained", exec_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
